// File: rtl/hilo_md_ctrl_if.sv
// E-stage <-> HI/LO multiply/divide sequencer handshake: issue fields in, busy and HI/LO out.
interface hilo_md_ctrl_if;
    logic        start;
    logic [3:0]  op;
    logic        cancel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, cancel, rs_val, rt_val, input busy, hi, lo);
    modport slave  (input start, op, cancel, rs_val, rt_val, output busy, hi, lo);
endinterface

// File: rtl/hilo_md_ctrl.sv
// HI/LO owner for the MIPS core: fixed-latency mult/div sequencer plus mthi/mtlo writes.
// Define MD_MADD_EN to add the madd/maddu/msub/msubu accumulate ops (7-10).
module hilo_md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    hilo_md_ctrl_if.slave  md
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        hi_q, lo_q;
    logic [31:0]        pend_hi, pend_lo;
    logic               pend_wr;
    logic               accept, commit;
    logic               is_mul, is_div, is_signed, wr_hi, wr_lo;
    logic [63:0]        op_a, op_b, prod;
    logic [31:0]        quot, rem;
`ifdef MD_MADD_EN
    logic               acc_en, acc_sub, pend_acc, pend_sub;
`endif

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no path infers a latch.
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
`ifdef MD_MADD_EN
        acc_en    = 1'b0;
        acc_sub   = 1'b0;
`endif
        case (md.op)
            OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_MTHI:  wr_hi = 1'b1;
            OP_MTLO:  wr_lo = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; is_signed = 1'b1; acc_en = 1'b1; end
            OP_MADDU: begin is_mul = 1'b1; acc_en = 1'b1; end
            OP_MSUB:  begin is_mul = 1'b1; is_signed = 1'b1; acc_en = 1'b1; acc_sub = 1'b1; end
            OP_MSUBU: begin is_mul = 1'b1; acc_en = 1'b1; acc_sub = 1'b1; end
`endif
            default:  ;
        endcase
    end

    // Low 64 bits of a 64x64 product of sign- or zero-extended operands is the 32x32 result.
    always_comb begin
        op_a = is_signed ? {{32{md.rs_val[31]}}, md.rs_val} : {32'b0, md.rs_val};
        op_b = is_signed ? {{32{md.rt_val[31]}}, md.rt_val} : {32'b0, md.rt_val};
        prod = op_a * op_b;
    end

    always_comb begin
        quot = '0;
        rem  = '0;
        if (md.rt_val != 32'd0) begin
            if (is_signed) begin
                quot = $signed(md.rs_val) / $signed(md.rt_val);
                rem  = $signed(md.rs_val) % $signed(md.rt_val);
            end else begin
                quot = md.rs_val / md.rt_val;
                rem  = md.rs_val % md.rt_val;
            end
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                accept = md.start & ~md.cancel;
                if (accept && (is_mul || is_div)) state_next = RUN;
            end
            RUN: begin
                if (cnt == '0) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            pend_hi  <= '0;
            pend_lo  <= '0;
            pend_wr  <= 1'b0;
`ifdef MD_MADD_EN
            pend_acc <= 1'b0;
            pend_sub <= 1'b0;
`endif
        end else if (accept && (is_mul || is_div)) begin
            cnt      <= is_mul ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
            pend_hi  <= is_mul ? prod[63:32] : rem;
            pend_lo  <= is_mul ? prod[31:0]  : quot;
            // Divide by zero still occupies the unit but leaves HI/LO untouched.
            pend_wr  <= is_mul || (md.rt_val != 32'd0);
`ifdef MD_MADD_EN
            pend_acc <= acc_en;
            pend_sub <= acc_sub;
`endif
        end else if (state == RUN && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit && pend_wr) begin
`ifdef MD_MADD_EN
            if (pend_acc) begin
                {hi_q, lo_q} <= pend_sub ? ({hi_q, lo_q} - {pend_hi, pend_lo})
                                         : ({hi_q, lo_q} + {pend_hi, pend_lo});
            end else begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
`else
            hi_q <= pend_hi;
            lo_q <= pend_lo;
`endif
        end else if (accept) begin
            if (wr_hi) hi_q <= md.rs_val;
            if (wr_lo) lo_q <= md.rs_val;
        end
    end

    assign md.busy = (state == RUN);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Directed bench for hilo_md_ctrl: vector table of issued ops plus multi-cycle corner sequences.
module tb_hilo_md_ctrl;
    localparam logic [3:0] OP_NOP = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3,
                           OP_DIVU = 4'd4, OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MADD = 4'd7,
                           OP_MADDU = 4'd8, OP_MSUB = 4'd9, OP_MSUBU = 4'd10;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        cancel;
        int          exp_busy;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] cur_hi, cur_lo;
    vec_t vecs[$];

    hilo_md_ctrl_if md();

    hilo_md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (md)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] op, input logic [31:0] rs,
                                input logic [31:0] rt, input logic cancel, input int exp_busy,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        vec_t v;
        v.name = name; v.op = op; v.rs = rs; v.rt = rt; v.cancel = cancel;
        v.exp_busy = exp_busy; v.exp_hi = exp_hi; v.exp_lo = exp_lo;
        return v;
    endfunction

    // Called at a negedge; counts busy samples until idle and flags any HI/LO change meanwhile.
    task automatic wait_idle(output int n, output bit hold_ok);
        n = 0;
        hold_ok = 1'b1;
        while (md.busy === 1'b1 && n < 50) begin
            n++;
            if (md.hi !== cur_hi || md.lo !== cur_lo) hold_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic cancel);
        md.start = 1'b1; md.op = op; md.rs_val = rs; md.rt_val = rt; md.cancel = cancel;
    endtask

    task automatic idle_inputs();
        md.start = 1'b0; md.op = OP_NOP; md.cancel = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit hold_ok;
        drive(v.op, v.rs, v.rt, v.cancel);
        @(negedge clk);
        idle_inputs();
        wait_idle(n, hold_ok);
        check({v.name, " busy_cycles"}, 64'(n), 64'(v.exp_busy));
        if (v.exp_busy > 0) check({v.name, " hold_during_run"}, 64'(hold_ok), 64'd1);
        check({v.name, " hi"}, 64'(md.hi), 64'(v.exp_hi));
        check({v.name, " lo"}, 64'(md.lo), 64'(v.exp_lo));
        cur_hi = v.exp_hi;
        cur_lo = v.exp_lo;
    endtask

    initial begin
        int  n;
        bit  hold_ok;

        vecs.push_back(mk("mult_neg",    OP_MULT,  32'hFFFFFFFD, 32'h5, 1'b0, 5, 32'hFFFFFFFF, 32'hFFFFFFF1));
        vecs.push_back(mk("multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5, 32'hFFFFFFFE, 32'h00000001));
        vecs.push_back(mk("divu_7_2",    OP_DIVU,  32'h7, 32'h2, 1'b0, 10, 32'h1, 32'h3));
        vecs.push_back(mk("div_m7_2",    OP_DIV,   32'hFFFFFFF9, 32'h2, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD));
        vecs.push_back(mk("div_7_m2",    OP_DIV,   32'h7, 32'hFFFFFFFE, 1'b0, 10, 32'h1, 32'hFFFFFFFD));
        vecs.push_back(mk("mthi",        OP_MTHI,  32'h12345678, 32'h0, 1'b0, 0, 32'h12345678, 32'hFFFFFFFD));
        vecs.push_back(mk("mtlo",        OP_MTLO,  32'h0000ABCD, 32'h0, 1'b0, 0, 32'h12345678, 32'h0000ABCD));
        vecs.push_back(mk("div_by_zero", OP_DIV,   32'h5, 32'h0, 1'b0, 10, 32'h12345678, 32'h0000ABCD));
        vecs.push_back(mk("mult_cancel", OP_MULT,  32'h2, 32'h3, 1'b1, 0, 32'h12345678, 32'h0000ABCD));
        vecs.push_back(mk("nop",         OP_NOP,   32'h1, 32'h1, 1'b0, 0, 32'h12345678, 32'h0000ABCD));
        vecs.push_back(mk("op_15",       4'd15,    32'h1, 32'h1, 1'b0, 0, 32'h12345678, 32'h0000ABCD));
        vecs.push_back(mk("mthi_0",      OP_MTHI,  32'h0, 32'h0, 1'b0, 0, 32'h0, 32'h0000ABCD));
        vecs.push_back(mk("mtlo_10",     OP_MTLO,  32'h10, 32'h0, 1'b0, 0, 32'h0, 32'h00000010));
`ifdef MD_MADD_EN
        vecs.push_back(mk("madd",        OP_MADD,  32'h3, 32'hFFFFFFFE, 1'b0, 5, 32'h0, 32'h0000000A));
        vecs.push_back(mk("msubu",       OP_MSUBU, 32'hFFFFFFFF, 32'h2, 1'b0, 5, 32'hFFFFFFFE, 32'h0000000C));
        vecs.push_back(mk("maddu",       OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5, 32'hFFFFFFFC, 32'h0000000D));
        vecs.push_back(mk("msub",        OP_MSUB,  32'h1, 32'hFFFFFFFF, 1'b0, 5, 32'hFFFFFFFC, 32'h0000000E));
`else
        vecs.push_back(mk("madd_off",    OP_MADD,  32'h3, 32'hFFFFFFFE, 1'b0, 0, 32'h0, 32'h00000010));
        vecs.push_back(mk("msubu_off",   OP_MSUBU, 32'hFFFFFFFF, 32'h2, 1'b0, 0, 32'h0, 32'h00000010));
        vecs.push_back(mk("maddu_off",   OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 32'h0, 32'h00000010));
        vecs.push_back(mk("msub_off",    OP_MSUB,  32'h1, 32'hFFFFFFFF, 1'b0, 0, 32'h0, 32'h00000010));
`endif

        reset_n = 1'b1;
        md.rs_val = '0;
        md.rt_val = '0;
        idle_inputs();
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(md.busy), 64'd0);
        check("reset hi", 64'(md.hi), 64'd0);
        check("reset lo", 64'(md.lo), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        cur_hi = '0;
        cur_lo = '0;

        // Each vector issues in the first idle cycle after the previous commit (back-to-back).
        foreach (vecs[i]) run_vec(vecs[i]);

        // A start arriving while RUN must be dropped, not queued.
        drive(OP_MULT, 32'h2, 32'h3, 1'b0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        drive(OP_MTHI, 32'hDEADBEEF, 32'h0, 1'b0);
        @(negedge clk);
        idle_inputs();
        wait_idle(n, hold_ok);
        check("run_ignore busy_tail", 64'(n), 64'd3);
        check("run_ignore hold", 64'(hold_ok), 64'd1);
        check("run_ignore hilo", {md.hi, md.lo}, {32'h0, 32'h6});
        @(negedge clk);
        check("run_ignore no_late_start", {31'b0, md.busy, md.hi, md.lo}, {32'h0, 32'h0, 32'h6});
        cur_hi = 32'h0;
        cur_lo = 32'h6;

        // cancel during RUN must not abort the older in-flight op.
        drive(OP_MULT, 32'h3, 32'h3, 1'b0);
        @(negedge clk);
        idle_inputs();
        md.cancel = 1'b1;
        @(negedge clk);
        md.cancel = 1'b0;
        wait_idle(n, hold_ok);
        check("cancel_in_run busy_tail", 64'(n), 64'd4);
        check("cancel_in_run hilo", {md.hi, md.lo}, {32'h0, 32'h9});

        // Asynchronous reset in RUN cycle 3 clears everything; the pending product never lands.
        drive(OP_MULT, 32'h7, 32'h7, 1'b0);
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        check("pre_reset busy", 64'(md.busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_reset busy", 64'(md.busy), 64'd0);
        check("mid_reset hilo", {md.hi, md.lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset busy", 64'(md.busy), 64'd0);
        check("post_reset hilo", {md.hi, md.lo}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
